// File: rtl/modulo_matriz_buffer.sv
// rtl/modulo_matriz_buffer.sv - ROWS x COLS LED matrix frame buffer with multiplexed row scanner
// Define MATRIZ_DBUF_EN for separate write/display buffers with a frame-aligned swap.
module modulo_matriz_buffer #(
  parameter int ROWS     = 7,
  parameter int COLS     = 5,
  parameter int SCAN_DIV = 50000,
  localparam int RW      = $clog2(ROWS)
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 wr_en,
  input  logic [RW-1:0]        wr_row,
  input  logic [COLS-1:0]      wr_data,
  input  logic                 clr_all,
  input  logic                 swap_req,
  output logic                 swap_ack,
  output logic                 frame_start,
  output logic [ROWS-1:0]      row_sel,
  output logic [COLS-1:0]      col_out,
  output logic [ROWS*COLS-1:0] frame_out
);

  localparam int CW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int RW1 = RW + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [RW:0]   ROW_LIM = RW1'(ROWS);

  logic [ROWS-1:0][COLS-1:0] wbuf;
  logic [ROWS-1:0][COLS-1:0] disp;
  logic [CW-1:0]             cnt;
  logic [RW-1:0]             row_idx;
  logic [RW-1:0]             next_row;
  logic                      tick;
  logic                      wrap;
  logic                      row_ok;

  assign tick      = (cnt == CNT_MAX);
  assign wrap      = tick && (row_idx == ROW_MAX);
  assign row_ok    = ({1'b0, wr_row} < ROW_LIM);
  assign frame_out = disp;

  always_comb begin
    next_row = row_idx;
    if (tick) next_row = (row_idx == ROW_MAX) ? '0 : row_idx + RW'(1);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wbuf <= '0;
    end else if (clr_all) begin
      wbuf <= '0;
    end else if (wr_en && row_ok) begin
      wbuf[wr_row] <= wr_data;
    end
  end

`ifdef MATRIZ_DBUF_EN
  logic pending;

  // Commit copies the pre-edge write buffer, so a same-cycle write lands only in wbuf.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      disp     <= '0;
      pending  <= 1'b0;
      swap_ack <= 1'b0;
    end else begin
      swap_ack <= wrap && pending;
      if (wrap && pending) begin
        disp    <= wbuf;
        pending <= 1'b0;
      end else if (swap_req) begin
        pending <= 1'b1;
      end
    end
  end
`else
  logic unused_swap_req;

  assign unused_swap_req = swap_req;
  assign disp            = wbuf;
  assign swap_ack        = 1'b0;
`endif

  // col_out samples the registered display, so content edits reach it one edge after frame_out.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt         <= '0;
      row_idx     <= '0;
      row_sel     <= ROWS'(1);
      col_out     <= '0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= tick ? '0 : cnt + CW'(1);
      row_idx     <= next_row;
      row_sel     <= ROWS'(1) << next_row;
      col_out     <= disp[next_row];
      frame_start <= wrap;
    end
  end

endmodule

// File: tb/tb_modulo_matriz_buffer.sv
// tb/tb_modulo_matriz_buffer.sv - randomized scoreboard bench for modulo_matriz_buffer
// Reference model follows MATRIZ_DBUF_EN the same way the design does.
module tb_modulo_matriz_buffer;

  localparam int ROWS = 7;
  localparam int COLS = 5;
  localparam int SD   = 3;
`ifdef MATRIZ_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  typedef struct packed {
    logic [ROWS-1:0]      row_sel;
    logic [COLS-1:0]      col_out;
    logic [ROWS*COLS-1:0] frame;
    logic                 fs;
    logic                 ack;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 clr;
  logic                 wr_en;
  logic [2:0]           wr_row;
  logic [COLS-1:0]      wr_data;
  logic                 clr_all;
  logic                 swap_req;
  logic                 swap_ack;
  logic                 frame_start;
  logic [ROWS-1:0]      row_sel;
  logic [COLS-1:0]      col_out;
  logic [ROWS*COLS-1:0] frame_out;

  int   checks = 0;
  int   errors = 0;
  int   ack_seen = 0;
  exp_t expq[$];

  int   wb[ROWS];
  int   db[ROWS];
  bit   pend;
  int   n;

  modulo_matriz_buffer #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD)) dut (
    .clk(clk), .clr(clr), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .clr_all(clr_all), .swap_req(swap_req), .swap_ack(swap_ack),
    .frame_start(frame_start), .row_sel(row_sel), .col_out(col_out),
    .frame_out(frame_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [ROWS*COLS-1:0] flatten(input bit from_db);
    logic [ROWS*COLS-1:0] f = '0;
    for (int i = 0; i < ROWS; i++) f[i*COLS +: COLS] = COLS'(from_db ? db[i] : wb[i]);
    return f;
  endfunction

  // One edge of stimulus; the model predicts what the DUT shows after that edge.
  task automatic cycle(input bit c, input bit we, input int row, input int data,
                       input bit ca, input bit sr);
    exp_t e;
    int   r;
    int   pre[ROWS];
    bit   fs;
    bit   commit;
    @(negedge clk);
    clr = c; wr_en = we; wr_row = 3'(row); wr_data = COLS'(data);
    clr_all = ca; swap_req = sr;
    if (c) begin
      n = 0; pend = 1'b0;
      for (int i = 0; i < ROWS; i++) begin wb[i] = 0; db[i] = 0; end
      e = '{row_sel: ROWS'(1), col_out: '0, frame: '0, fs: 1'b0, ack: 1'b0};
    end else begin
      n++;
      r  = (n / SD) % ROWS;
      fs = (n % (ROWS * SD)) == 0;
      for (int i = 0; i < ROWS; i++) pre[i] = DBUF ? db[i] : wb[i];
      commit = DBUF && fs && pend;
      if (commit) begin
        for (int i = 0; i < ROWS; i++) db[i] = wb[i];
        pend = 1'b0;
      end else if (DBUF && sr) begin
        pend = 1'b1;
      end
      if (ca) begin
        for (int i = 0; i < ROWS; i++) wb[i] = 0;
      end else if (we && row < ROWS) begin
        wb[row] = data & ((1 << COLS) - 1);
      end
      e.row_sel = ROWS'(1 << r);
      e.col_out = COLS'(pre[r]);
      e.frame   = flatten(DBUF);
      e.fs      = fs;
      e.ack     = commit;
    end
    expq.push_back(e);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain;
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("row_sel", 64'(row_sel), 64'(e.row_sel));
        check("col_out", 64'(col_out), 64'(e.col_out));
        check("frame_out", 64'(frame_out), 64'(e.frame));
        check("frame_start", 64'(frame_start), 64'(e.fs));
        check("swap_ack", 64'(swap_ack), 64'(e.ack));
        if (swap_ack) ack_seen++;
      end
    end
  end

  initial begin : stimulus
    int acks0;
    clr = 1'b1; wr_en = 1'b0; wr_row = '0; wr_data = '0; clr_all = 1'b0; swap_req = 1'b0;
    n = 0; pend = 1'b0;
    for (int i = 0; i < ROWS; i++) begin wb[i] = 0; db[i] = 0; end
    repeat (2) @(negedge clk);
    #1;
    check("reset_row_sel", 64'(row_sel), 64'h01);
    check("reset_col_out", 64'(col_out), 64'h0);
    check("reset_frame_out", 64'(frame_out), 64'h0);
    check("reset_swap_ack", 64'(swap_ack), 64'h0);

    // Plain scanning across two full frames.
    idle(45);

    // Writes, including an out-of-range row and clr_all racing wr_en.
    cycle(0, 1, 2, 5'b10101, 0, 0);
    cycle(0, 1, 7, 5'b11111, 0, 0);
    idle(8);
    cycle(0, 1, 3, 5'b01110, 0, 0);
    cycle(0, 1, 3, 5'b11111, 1, 0);
    idle(12);

    // Reset asserted while row 4 is active.
    cycle(1, 0, 0, 0, 0, 0);
    idle(13);
    cycle(1, 0, 0, 0, 0, 0);
    #1;
    check("midscan_row_sel", 64'(row_sel), 64'h01);
    check("midscan_col_out", 64'(col_out), 64'h0);
    check("midscan_frame_out", 64'(frame_out), 64'h0);
    check("midscan_swap_ack", 64'(swap_ack), 64'h0);
    check("midscan_frame_start", 64'(frame_start), 64'h0);
    drain();
    acks0 = ack_seen;

    // Fill, then three swap requests mid-frame: exactly one commit at the wrap.
    for (int r = 0; r < ROWS; r++) cycle(0, 1, r, 5'b11111, 0, 0);
    idle(3);
    cycle(0, 0, 0, 0, 0, 1);
    idle(1);
    cycle(0, 0, 0, 0, 0, 1);
    idle(1);
    cycle(0, 0, 0, 0, 0, 1);
    idle(15);
    drain();
    check("swap_ack_count", 64'(ack_seen - acks0), DBUF ? 64'd1 : 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
            $urandom_range(0, 31), $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
    end
    drain();
    check("queue_drained", 64'(expq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
